// File: rtl/atm_pkg.sv
// Shared definitions for the ATM event collector and its round-robin helpers.
package atm_pkg;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CH_W   = 2;

   typedef enum logic {IDLE, PRESENT} state_e;
endpackage

// File: rtl/mux4to1_event_collector_if.sv
// Delivery channel of the event collector: channel index S, valid F, consumer ACK.
interface mux4to1_event_collector_if;
   import atm_pkg::*;

   logic [CH_W-1:0] S;
   logic            F;
   logic            ACK;

   modport master (output S, output F, input ACK);
   modport slave  (input S, input F, output ACK);
endinterface

// File: rtl/mux4to1_event_collector_rr_pick4.sv
// Combinational round-robin picker: first set request searching ptr, ptr+1, ... (mod 4).
module rr_pick4
   import atm_pkg::*;
(
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   output logic              any_o,
   output logic [CH_W-1:0]   idx_o
);
   logic [CH_W-1:0] cand;

   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         cand = ptr_i + CH_W'(k);
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
   end
endmodule

// File: rtl/mux4to1_event_collector.sv
// Collects events from four channels into pending latches and delivers them one at a
// time on the S/F handshake, served round-robin.
module mux4to1_event_collector
   import atm_pkg::*;
#(
   parameter int unsigned EDGE_DETECT = 1,
   parameter int unsigned START_PTR   = 0
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              Y0,
   input  logic              Y1,
   input  logic              Y2,
   input  logic              Y3,
   input  logic              CLR_OVF,
   output logic [NUM_CH-1:0] PEND,
   output logic [NUM_CH-1:0] OVF,
   mux4to1_event_collector_if.master dlv
);
   state_e            state_q, state_d;
   logic [CH_W-1:0]   s_q, s_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [NUM_CH-1:0] y_prev_q;
   logic [NUM_CH-1:0] y, ev, gnt;
   logic              pick_any;
   logic [CH_W-1:0]   pick_idx;

   assign y = {Y3, Y2, Y1, Y0};

   always_comb begin
      ev = (EDGE_DETECT != 0) ? (y & ~y_prev_q) : y;
   end

   rr_pick4 u_pick (
      .req_i (pend_q),
      .ptr_i (ptr_q),
      .any_o (pick_any),
      .idx_o (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      ptr_d   = ptr_q;
      gnt     = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               s_d           = pick_idx;
               gnt[pick_idx] = 1'b1;
               state_d       = PRESENT;
            end
         end
         PRESENT: begin
            if (dlv.ACK) begin
               ptr_d   = s_q + 1'b1;
               state_d = IDLE;
            end
         end
      endcase
      // A new event beats the grant-clear; overflow only when the bit stays occupied.
      pend_d = (pend_q & ~gnt) | ev;
      ovf_d  = (CLR_OVF ? '0 : ovf_q) | (ev & pend_q & ~gnt);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         s_q      <= '0;
         ptr_q    <= CH_W'(START_PTR);
         pend_q   <= '0;
         ovf_q    <= '0;
         y_prev_q <= '1;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         ptr_q    <= ptr_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         y_prev_q <= y;
      end
   end

   assign dlv.S = s_q;
   assign dlv.F = (state_q == PRESENT);
   assign PEND  = pend_q;
   assign OVF   = ovf_q;
endmodule

// File: tb/tb_mux4to1_event_collector.sv
// Scoreboard bench: stimulus queues expected channel indices, monitors pop them on each delivery.
module tb_mux4to1_event_collector;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] y_e = '0, y_l = '0;
   logic       clr_e = 1'b0, clr_l = 1'b0;
   logic [3:0] pend_e, ovf_e, pend_l, ovf_l;
   logic [1:0] q_e[$];
   logic [1:0] q_l[$];
   logic       fprev_e = 1'b0, fprev_l = 1'b0;
   int         n_chk = 0;
   int         n_fail = 0;

   mux4to1_event_collector_if dv_e ();
   mux4to1_event_collector_if dv_l ();

   mux4to1_event_collector #(.EDGE_DETECT(1), .START_PTR(0)) dut_e (
      .CLK(clk), .RST(rst), .Y0(y_e[0]), .Y1(y_e[1]), .Y2(y_e[2]), .Y3(y_e[3]),
      .CLR_OVF(clr_e), .PEND(pend_e), .OVF(ovf_e), .dlv(dv_e)
   );

   mux4to1_event_collector #(.EDGE_DETECT(0), .START_PTR(0)) dut_l (
      .CLK(clk), .RST(rst), .Y0(y_l[0]), .Y1(y_l[1]), .Y2(y_l[2]), .Y3(y_l[3]),
      .CLR_OVF(clr_l), .PEND(pend_l), .OVF(ovf_l), .dlv(dv_l)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      y_e = '0; y_l = '0; clr_e = 1'b0; clr_l = 1'b0;
      dv_e.ACK = 1'b0; dv_l.ACK = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   always @(negedge clk) begin
      if (dv_e.F === 1'b1 && fprev_e !== 1'b1) begin
         if (q_e.size() == 0) chk("edge_unexpected_delivery", {6'd0, dv_e.S}, 8'hff);
         else chk("edge_delivery_S", {6'd0, dv_e.S}, {6'd0, q_e.pop_front()});
      end
      fprev_e = dv_e.F;
   end

   always @(negedge clk) begin
      if (dv_l.F === 1'b1 && fprev_l !== 1'b1) begin
         if (q_l.size() == 0) chk("level_unexpected_delivery", {6'd0, dv_l.S}, 8'hff);
         else chk("level_delivery_S", {6'd0, dv_l.S}, {6'd0, q_l.pop_front()});
      end
      fprev_l = dv_l.F;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] seq_a [4];
      logic [1:0] seq_b [4];
      seq_a = '{2'd0, 2'd1, 2'd2, 2'd3};
      seq_b = '{2'd2, 2'd3, 2'd0, 2'd1};
      dv_e.ACK = 1'b0; dv_l.ACK = 1'b0;

      // Reset with Y1 held high: no event afterwards
      y_e = 4'b0010; rst = 1'b1;
      tick(2);
      chk("rst_F", {7'd0, dv_e.F}, 8'd0);
      chk("rst_S", {6'd0, dv_e.S}, 8'd0);
      chk("rst_PEND", {4'd0, pend_e}, 8'd0);
      chk("rst_OVF", {4'd0, ovf_e}, 8'd0);
      rst = 1'b0;
      tick(3);
      chk("held_high_PEND", {4'd0, pend_e}, 8'd0);
      chk("held_high_F", {7'd0, dv_e.F}, 8'd0);
      y_e = '0;
      tick(1);

      // Single event on channel 2
      do_reset();
      q_e.push_back(2'd2);
      y_e = 4'b0100; tick(1);
      chk("single_PEND", {4'd0, pend_e}, 8'h04);
      chk("single_F_early", {7'd0, dv_e.F}, 8'd0);
      y_e = '0; tick(1);
      chk("single_F", {7'd0, dv_e.F}, 8'd1);
      chk("single_S", {6'd0, dv_e.S}, 8'd2);
      chk("single_PEND_clr", {4'd0, pend_e}, 8'd0);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("single_hold_F", {7'd0, dv_e.F}, 8'd1);
         chk("single_hold_S", {6'd0, dv_e.S}, 8'd2);
      end
      dv_e.ACK = 1'b1; tick(1);
      chk("single_ack_F", {7'd0, dv_e.F}, 8'd0);
      chk("single_ack_S", {6'd0, dv_e.S}, 8'd2);
      chk("single_ack_PEND", {4'd0, pend_e}, 8'd0);
      dv_e.ACK = 1'b0;

      // Round-robin from ptr=0, then from ptr=2
      do_reset();
      dv_e.ACK = 1'b1;
      foreach (seq_a[i]) q_e.push_back(seq_a[i]);
      y_e = 4'b1111; tick(1);
      chk("rr_PEND_all", {4'd0, pend_e}, 8'h0f);
      y_e = '0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("rr_a_F_hi", {7'd0, dv_e.F}, 8'd1);
         chk("rr_a_S", {6'd0, dv_e.S}, {6'd0, seq_a[i]});
         tick(1);
         chk("rr_a_F_lo", {7'd0, dv_e.F}, 8'd0);
      end
      q_e.push_back(2'd1);
      y_e = 4'b0010; tick(1);
      y_e = '0; tick(1);
      chk("rr_ptr_set_S", {6'd0, dv_e.S}, 8'd1);
      tick(1);
      foreach (seq_b[i]) q_e.push_back(seq_b[i]);
      y_e = 4'b1111; tick(1);
      y_e = '0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("rr_b_F_hi", {7'd0, dv_e.F}, 8'd1);
         chk("rr_b_S", {6'd0, dv_e.S}, {6'd0, seq_b[i]});
         tick(1);
         chk("rr_b_F_lo", {7'd0, dv_e.F}, 8'd0);
      end
      dv_e.ACK = 1'b0;

      // Overflow and CLR_OVF priority
      do_reset();
      q_e.push_back(2'd1); q_e.push_back(2'd1);
      y_e = 4'b0010; tick(1);
      y_e = '0; tick(1);
      chk("ovf_first_S", {6'd0, dv_e.S}, 8'd1);
      y_e = 4'b0010; tick(1);
      chk("ovf_second_PEND", {4'd0, pend_e}, 8'h02);
      chk("ovf_second_OVF", {4'd0, ovf_e}, 8'h00);
      y_e = '0; tick(1);
      y_e = 4'b0010; tick(1);
      chk("ovf_third_PEND", {4'd0, pend_e}, 8'h02);
      chk("ovf_third_OVF", {4'd0, ovf_e}, 8'h02);
      y_e = '0; clr_e = 1'b1; tick(1);
      chk("ovf_clr", {4'd0, ovf_e}, 8'h00);
      y_e = 4'b0010; tick(1);
      chk("ovf_beats_clr", {4'd0, ovf_e}, 8'h02);
      y_e = '0; clr_e = 1'b0; tick(1);
      chk("ovf_sticky", {4'd0, ovf_e}, 8'h02);
      clr_e = 1'b1; tick(1);
      clr_e = 1'b0;
      chk("ovf_clr2", {4'd0, ovf_e}, 8'h00);
      dv_e.ACK = 1'b1; tick(1);
      chk("ovf_ack_F", {7'd0, dv_e.F}, 8'd0);
      chk("ovf_ack_PEND", {4'd0, pend_e}, 8'h02);
      dv_e.ACK = 1'b0; tick(1);
      chk("ovf_redeliver_S", {6'd0, dv_e.S}, 8'd1);
      chk("ovf_redeliver_PEND", {4'd0, pend_e}, 8'h00);
      dv_e.ACK = 1'b1; tick(1);
      dv_e.ACK = 1'b0;

      // New Y3 edge on the edge channel 3 is granted: set wins
      do_reset();
      q_e.push_back(2'd0); q_e.push_back(2'd3); q_e.push_back(2'd3);
      y_e = 4'b0001; tick(1);
      y_e = '0; tick(1);
      y_e = 4'b1000; tick(1);
      y_e = '0; dv_e.ACK = 1'b1; tick(1);
      dv_e.ACK = 1'b0; y_e = 4'b1000; tick(1);
      chk("setwin_S", {6'd0, dv_e.S}, 8'd3);
      chk("setwin_PEND", {4'd0, pend_e}, 8'h08);
      chk("setwin_OVF", {4'd0, ovf_e}, 8'h00);
      y_e = '0; dv_e.ACK = 1'b1; tick(1);
      dv_e.ACK = 1'b0; tick(1);
      chk("setwin_again_F", {7'd0, dv_e.F}, 8'd1);
      chk("setwin_again_PEND", {4'd0, pend_e}, 8'h00);
      dv_e.ACK = 1'b1; tick(1);
      dv_e.ACK = 1'b0;

      // Reset mid-delivery with pending and overflow state
      do_reset();
      q_e.push_back(2'd2); q_e.push_back(2'd1);
      y_e = 4'b0100; tick(1);
      y_e = '0; tick(1);
      dv_e.ACK = 1'b1; tick(1);
      dv_e.ACK = 1'b0;
      y_e = 4'b0010; tick(1);
      y_e = '0; tick(1);
      chk("midrst_pre_S", {6'd0, dv_e.S}, 8'd1);
      y_e = 4'b0010; tick(1);
      y_e = '0; tick(1);
      y_e = 4'b0010; tick(1);
      y_e = '0;
      chk("midrst_pre_OVF", {4'd0, ovf_e}, 8'h02);
      rst = 1'b1; tick(1);
      chk("midrst_F", {7'd0, dv_e.F}, 8'd0);
      chk("midrst_PEND", {4'd0, pend_e}, 8'h00);
      chk("midrst_OVF", {4'd0, ovf_e}, 8'h00);
      rst = 1'b0; tick(1);
      q_e.push_back(2'd1); q_e.push_back(2'd3);
      y_e = 4'b1010; tick(1);
      y_e = '0; tick(1);
      chk("midrst_ptr_S", {6'd0, dv_e.S}, 8'd1);
      dv_e.ACK = 1'b1; tick(3);
      dv_e.ACK = 1'b0;
      chk("midrst_end_PEND", {4'd0, pend_e}, 8'h00);

      // Level mode: Y0 high for three cycles with ACK tied high
      do_reset();
      dv_l.ACK = 1'b1;
      q_l.push_back(2'd0); q_l.push_back(2'd0);
      y_l = 4'b0001; tick(1);
      chk("lvl_e1_PEND", {4'd0, pend_l}, 8'h01);
      tick(1);
      chk("lvl_e2_F", {7'd0, dv_l.F}, 8'd1);
      chk("lvl_e2_OVF", {4'd0, ovf_l}, 8'h00);
      tick(1);
      chk("lvl_e3_OVF", {4'd0, ovf_l}, 8'h01);
      chk("lvl_e3_PEND", {4'd0, pend_l}, 8'h01);
      y_l = '0; tick(1);
      chk("lvl_e4_F", {7'd0, dv_l.F}, 8'd1);
      chk("lvl_e4_PEND", {4'd0, pend_l}, 8'h00);
      tick(1);
      chk("lvl_e5_F", {7'd0, dv_l.F}, 8'd0);
      dv_l.ACK = 1'b0;

      tick(2);
      chk("edge_queue_drained", q_e.size(), 8'd0);
      chk("level_queue_drained", q_l.size(), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
